// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared front-end types. decode_data is the record produced by the decode
// stage and consumed by rename. DECODE_Q_DEPTH is the default decode queue
// depth. Rename uses the same constant to size its credit counter.
// -----------------------------------------------------------------------------
package types_pkg;

   localparam int DECODE_Q_DEPTH = 4;

   // RV32I major opcodes recognised by the decoder.
   typedef enum logic [6:0] {
      OP_LUI    = 7'h37,
      OP_AUIPC  = 7'h17,
      OP_JAL    = 7'h6f,
      OP_JALR   = 7'h67,
      OP_BRANCH = 7'h63,
      OP_LOAD   = 7'h03,
      OP_STORE  = 7'h23,
      OP_IMM    = 7'h13,
      OP_REG    = 7'h33
   } opcode_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
   } decode_data;

endpackage

// File: rtl/decode_queue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_queue_ctrl
// Pointer, occupancy and handshake control for decode_queue. Flush wins over
// any same-cycle enqueue or dequeue and returns the queue to the empty state.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_valid_in   : fetch presents an instruction
//   i_ready_out  : rename accepts the head entry
//   i_flush      : discard all entries
//   o_ready_in   : queue has a free slot
//   o_valid_out  : queue holds at least one entry
//   o_enq        : write mem[o_wr_ptr] this cycle
//   o_wr_ptr     : next slot to write
//   o_rd_ptr     : head slot
//   o_count      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module decode_queue_ctrl #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid_in,
   input  logic             i_ready_out,
   input  logic             i_flush,
   output logic             o_ready_in,
   output logic             o_valid_out,
   output logic             o_enq,
   output logic [PTR_W-1:0] o_wr_ptr,
   output logic [PTR_W-1:0] o_rd_ptr,
   output logic [CNT_W-1:0] o_count
);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_ready_in;
   logic             w_valid_out;
   logic             w_enq;
   logic             w_deq;

   // Explicit wrap so that a non-power-of-two DEPTH never indexes past the end.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // ready_in depends only on the registered count. A dequeue in the same cycle
   // does not open a slot until the next cycle.
   assign w_ready_in  = (r_count < CNT_W'(DEPTH));
   assign w_valid_out = (r_count != '0);
   assign w_enq       = i_valid_in  & w_ready_in  & ~i_flush;
   assign w_deq       = w_valid_out & i_ready_out & ~i_flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_enq & ~w_deq)      r_count <= r_count + CNT_W'(1);
         else if (w_deq & ~w_enq) r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_ready_in  = w_ready_in;
   assign o_valid_out = w_valid_out;
   assign o_enq       = w_enq;
   assign o_wr_ptr    = r_wr_ptr;
   assign o_rd_ptr    = r_rd_ptr;
   assign o_count     = r_count;

endmodule

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Builds the sign-extended RV32I immediate for the format implied by the
// opcode. Opcodes that carry no immediate produce zero.
//   i_instr : 32-bit instruction word
//   o_imm   : 32-bit immediate
// -----------------------------------------------------------------------------
module imm_gen
   import types_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [31:0] o_imm
);

   always_comb begin
      // NOTE: give every combinational output a value before the case so that
      // no path leaves it unassigned, which would infer a latch.
      o_imm = '0;
      case (i_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR:
            o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         OP_STORE:
            o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         OP_BRANCH:
            o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            o_imm = {i_instr[31:12], 12'h000};
         OP_JAL:
            o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                     i_instr[20], i_instr[30:21], 1'b0};
         default:
            o_imm = '0;
      endcase
   end

endmodule

// File: rtl/signal_decode.sv
// -----------------------------------------------------------------------------
// signal_decode
// Extracts register fields and derives control signals from an instruction.
// The register fields are raw bit slices for every format. reg_write and the
// other flags tell rename which fields are meaningful. pc and imm are left at
// zero. The caller fills them in.
//   i_instr : 32-bit instruction word
//   o_dec   : partially filled decode_data
// -----------------------------------------------------------------------------
module signal_decode
   import types_pkg::*;
(
   input  logic [31:0] i_instr,
   output decode_data  o_dec
);

   always_comb begin
      o_dec        = '0;
      o_dec.opcode = i_instr[6:0];
      o_dec.rd     = i_instr[11:7];
      o_dec.funct3 = i_instr[14:12];
      o_dec.rs1    = i_instr[19:15];
      o_dec.rs2    = i_instr[24:20];
      o_dec.funct7 = i_instr[31:25];
      case (i_instr[6:0])
         OP_LUI, OP_AUIPC, OP_IMM: begin
            o_dec.reg_write = 1'b1;
            o_dec.alu_src   = 1'b1;
         end
         OP_JAL: begin
            o_dec.reg_write = 1'b1;
            o_dec.jump      = 1'b1;
         end
         OP_JALR: begin
            o_dec.reg_write = 1'b1;
            o_dec.jump      = 1'b1;
            o_dec.alu_src   = 1'b1;
         end
         OP_BRANCH:
            o_dec.branch = 1'b1;
         OP_LOAD: begin
            o_dec.reg_write = 1'b1;
            o_dec.mem_read  = 1'b1;
            o_dec.alu_src   = 1'b1;
         end
         OP_STORE: begin
            o_dec.mem_write = 1'b1;
            o_dec.alu_src   = 1'b1;
         end
         OP_REG:
            o_dec.reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
// Registered decode stage between fetch and rename. Each accepted instruction
// is decoded and stored in a DEPTH-entry in-order queue. Rename drains the
// queue through a valid/ready handshake. Flush empties the queue on a
// mispredict. There is no bypass, so an entry is visible one cycle after it
// is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   instr      : fetched instruction         pc_in     : its PC
//   valid_in   : fetch presents instr        ready_in  : a slot is free
//   flush      : discard all entries
//   ready_out  : rename accepts data_out     valid_out : data_out is valid
//   data_out   : head entry, zero when empty count     : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module decode_queue
   import types_pkg::*;
#(
   parameter  int DEPTH = DECODE_Q_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic [31:0]      pc_in,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic             flush,
   input  logic             ready_out,
   output logic             valid_out,
   output decode_data       data_out,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] w_wr_ptr;
   logic [PTR_W-1:0] w_rd_ptr;
   logic             w_enq;
   logic             w_valid_out;
   logic [31:0]      w_imm;
   decode_data       w_dec;
   decode_data       w_wr_data;
   decode_data       r_mem [DEPTH];

   imm_gen u_imm_gen (
      .i_instr (instr),
      .o_imm   (w_imm)
   );

   signal_decode u_signal_decode (
      .i_instr (instr),
      .o_dec   (w_dec)
   );

   always_comb begin
      w_wr_data     = w_dec;
      w_wr_data.pc  = pc_in;
      w_wr_data.imm = w_imm;
   end

   decode_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid_in  (valid_in),
      .i_ready_out (ready_out),
      .i_flush     (flush),
      .o_ready_in  (ready_in),
      .o_valid_out (w_valid_out),
      .o_enq       (w_enq),
      .o_wr_ptr    (w_wr_ptr),
      .o_rd_ptr    (w_rd_ptr),
      .o_count     (count)
   );

   // NOTE: storage has no reset. An entry is read only after it has been
   // written, and data_out is forced to zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[w_wr_ptr] <= w_wr_data;
   end

   assign valid_out = w_valid_out;
   assign data_out  = w_valid_out ? r_mem[w_rd_ptr] : '0;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Registered, buffered successor to the combinational decode stage; sits between fetch and rename.
- Decodes each accepted instruction with the existing imm_gen and signal_decode sub-modules.
- Stores the resulting decode_data in a DEPTH-entry in-order queue.
- Presents entries to rename through a valid/ready handshake.
- Adds what the combinational stage lacks: decoupling between fetch and rename, an occupancy count, and a pipeline flush for branch mispredict recovery.

Parameters:
DEPTH, 4, number of queue entries; any integer >= 2 (not restricted to powers of two).
PTR_W, $clog2(DEPTH), localparam; read/write pointer width.
CNT_W, $clog2(DEPTH+1), localparam; occupancy counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr  in  32  fetched instruction.
pc_in  in  32  PC of instr.
valid_in  in  1  fetch presents instr/pc_in.
ready_in  out  1  queue can accept this cycle.
flush  in  1  discard all queued entries (mispredict).
ready_out  in  1  rename can accept data_out.
valid_out  out  1  data_out holds a valid decoded entry.
data_out  out  decode_data  head entry (types_pkg struct).
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during reset: valid_out=0, data_out='0, ready_in=1.
  - Storage array is not reset.
- Combinational outputs:
  - ready_in = (count < DEPTH). No enqueue-when-full even if a dequeue happens in the same cycle.
  - valid_out = (count != 0).
  - data_out = mem[rd_ptr] when valid_out=1, else '0.
- Enqueue (enq) = valid_in & ready_in & ~flush.
  - On enq, at the rising edge: mem[wr_ptr] <= {decoded fields of instr, pc=pc_in}.
  - wr_ptr advances, wrapping DEPTH-1 -> 0.
- Dequeue (deq) = valid_out & ready_out & ~flush.
  - On deq: rd_ptr advances, wrapping DEPTH-1 -> 0.
- Count update:
  - enq & ~deq: count+1.
  - deq & ~enq: count-1.
  - enq & deq: count unchanged.
- Latency: an accepted instruction appears on data_out with valid_out=1 exactly 1 cycle later, when the queue was empty. There is no combinational bypass from instr to data_out.
- Ordering: strictly FIFO. data_out is stable while valid_out=1 and ready_out=0.
- Flush has priority over everything else.
  - At the edge: wr_ptr=rd_ptr=0, count=0.
  - Any same-cycle enq/deq is ignored; fetch must re-present after redirect.
  - Cycle after flush: valid_out=0, ready_in=1.
- Boundaries:
  - Full: ready_in=0; a deq in that cycle frees the slot for the next cycle only.
  - Empty: valid_out=0; ready_out is ignored.
  - Pointer wrap for non-power-of-two DEPTH uses explicit compare-to-(DEPTH-1), not natural overflow.
  - Reset asserted mid-stream: all entries are dropped immediately; outputs take their reset values asynchronously.
- Handshake rules:
  - valid_in may deassert without acceptance; no obligation on fetch.
  - valid_out never deasserts without a deq or flush.

Decomposition:
- types_pkg: decode_data (existing, unchanged).
- types_pkg additions: DECODE_Q_DEPTH default constant, shared with the rename stage for credit sizing.
- Instantiate the existing imm_gen and signal_decode on the instr input to build the write-data struct.
- One natural new sub-module: decode_queue_ctrl, holding pointers, count, flush priority, and ready/valid generation. The storage array stays in decode_queue.

Test Plan:
- Single instruction: reset, then instr=0x00500093 (addi x1,x0,5), pc_in=0x100, valid_in=1 for one cycle, ready_out=1 → next cycle valid_out=1, data_out.rd=1, rs1=0, imm=5, pc=0x100; following cycle valid_out=0, count=0.
- Fill to full: DEPTH=4, ready_out=0, present 5 instrs (pcs 0x0,0x4,0x8,0xC,0x10) → first 4 accepted, count=4, ready_in=0; 0x10 held off. Then ready_out=1 for one cycle → 0x10 accepted the cycle after; output order 0x0,0x4,0x8,0xC,0x10.
- Simultaneous enq/deq: count=2, valid_in=1, ready_out=1 for 3 cycles → count stays 2; pcs emerge in issue order.
- Flush priority: count=3, flush=1 with valid_in=1 and ready_out=1 in the same cycle → next cycle count=0, valid_out=0, ready_in=1; the presented instr never appears on data_out.
- Wrap stress: DEPTH=3 and DEPTH=4, 20 instrs (pcs 0x0..0x4C) with ready_out toggling pseudo-randomly → all 20 emerge in order, none duplicated or lost. count always equals accepted minus dequeued.
- Async reset mid-operation: count=2, drop rst_n between clock edges → immediately valid_out=0, data_out='0, count=0. After release, queue behaves as freshly reset.
